// File: rtl/axis_fifo_rr_arbiter_pkg.sv
// Shared types and defaults for the packet-aware round-robin
// stream arbiter feeding the 128-bit stream FIFO.
package axis_fifo_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_DATA_W = 128;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_fifo_rr_arbiter_rr_priority_pick.sv
// Rotating-priority encoder: first set request after ptr_i,
// searching ptr_i+1, ptr_i+2, ... modulo N.
module rr_priority_pick
  import axis_fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_any_o
);

  logic [IW-1:0] cand [N];

  for (genvar i = 0; i < N; i++) begin : g_cand
    logic [IW:0] sum;
    assign sum = {1'b0, ptr_i} + (IW+1)'(i + 1);
    assign cand[i] = (sum >= (IW+1)'(N)) ?
                     IW'(sum - (IW+1)'(N)) : IW'(sum);
  end

  // Walk from the farthest candidate so the nearest one wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[cand[i]]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = cand[i];
      end
    end
  end

endmodule

// File: rtl/axis_fifo_rr_arbiter.sv
// Packet-aware round-robin arbiter steering N_REQ AXI4-Stream
// sources onto a single stream FIFO write port.
module axis_fifo_rr_arbiter
  import axis_fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned IDX_W    = idx_w(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        s_tvalid_i,
  input  logic [N_REQ-1:0]        s_tlast_i,
  input  logic [N_REQ*DATA_W-1:0] s_tdata_i,
  output logic [N_REQ-1:0]        s_tready_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_wr_en_o,
  output logic [DATA_W-1:0]       fifo_wr_data_o,
  output logic                    grant_vld_o,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic                    pkt_done_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             xfer, beat;
  logic             rel_last, rel_cap;

  rr_priority_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req_i     (s_tvalid_i),
    .ptr_i     (ptr_q),
    .gnt_idx_o (pick_idx),
    .gnt_any_o (pick_any)
  );

  // rst_ni gates the handshake so a reset pulse drops it at once.
  assign xfer     = rst_ni && (state_q == ST_XFER);
  assign beat     = xfer && !fifo_full_i && s_tvalid_i[gnt_q];
  assign rel_last = beat && s_tlast_i[gnt_q];
  assign rel_cap  = beat && (cnt_q == CNT_LAST);

  always_comb begin
    s_tready_o = '0;
    if (xfer && !fifo_full_i) begin
      s_tready_o[gnt_q] = 1'b1;
    end
  end

  always_comb begin
    fifo_wr_data_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q == IDX_W'(k)) begin
        fifo_wr_data_o = s_tdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign fifo_wr_en_o = beat;
  assign grant_vld_o  = (state_q == ST_XFER);
  assign grant_idx_o  = gnt_q;
  assign pkt_done_o   = done_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_XFER;
          gnt_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        if (rel_last || rel_cap) begin
          state_d = ST_IDLE;
          ptr_d   = gnt_q;
          cnt_d   = '0;
          done_d  = rel_last;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Directed bench for axis_fifo_rr_arbiter with a cycle-level
// reference model and a small draining FIFO model.
module tb_axis_fifo_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    tvalid = '0;
  logic [N-1:0]    tlast = '0;
  logic [N*DW-1:0] tdata = '0;
  logic [N-1:0]    tready;
  logic            full = 1'b0;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            gvld;
  logic [IW-1:0]   gidx;
  logic            done;

  always #5 clk = ~clk;

  axis_fifo_rr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .s_tvalid_i     (tvalid),
    .s_tlast_i      (tlast),
    .s_tdata_i      (tdata),
    .s_tready_o     (tready),
    .fifo_full_i    (full),
    .fifo_wr_en_o   (wr_en),
    .fifo_wr_data_o (wr_data),
    .grant_vld_o    (gvld),
    .grant_idx_o    (gidx),
    .pkt_done_o     (done)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [DW:0]   srcq [N][$];
  logic [N-1:0]  acc = '0;
  logic          wr_seen = 1'b0;
  logic          force_full = 1'b0;
  int            fcnt = 0;

  logic [DW-1:0] wr_log [$];
  int            wr_cyc [$];
  int            gnt_log [$];
  int            gnt_cyc [$];
  int            done_cnt = 0;
  logic          prev_gvld = 1'b0;

  bit            m_busy = 0;
  int            m_idx = 0;
  int            m_ptr = N - 1;
  int            m_beats = 0;
  bit            m_done = 0;
  logic [N-1:0]  e_rdy;
  logic          e_wr;
  logic [DW-1:0] e_data;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    else
      passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int src, input int n,
                      input logic [DW-1:0] base);
    logic l;
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1);
      srcq[src].push_back({l, base + DW'(i)});
    end
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int k = 0; k < N; k++)
      if (srcq[k].size() > 0) p = 1;
    return p;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pending() || gvld) && n < budget) begin
      look();
      n++;
    end
    look();
    look();
    chk("idle_timeout", n < budget, 1);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Sources and FIFO: update away from both edges.
  always begin
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++)
      if (acc[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
    if (wr_seen) fcnt++;
    if (fcnt > 0) fcnt--;
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        tvalid[k] = 1'b1;
        tlast[k]  = srcq[k][0][DW];
        tdata[k*DW +: DW] = srcq[k][0][DW-1:0];
      end else begin
        tvalid[k] = 1'b0;
        tlast[k]  = 1'b0;
        tdata[k*DW +: DW] = '0;
      end
    end
    full = force_full || (fcnt >= 8);
  end

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    cyc++;
    e_rdy  = '0;
    e_wr   = 1'b0;
    e_data = '0;
    if (!rst_n) begin
      m_busy  = 0;
      m_idx   = 0;
      m_ptr   = N - 1;
      m_beats = 0;
      m_done  = 0;
    end else if (m_busy && !full) begin
      e_rdy[m_idx] = 1'b1;
      e_wr   = tvalid[m_idx];
      e_data = tdata[m_idx*DW +: DW];
    end
    chk("grant_vld", gvld, m_busy);
    chk("grant_idx", gidx, m_idx);
    chk("pkt_done", done, m_done);
    chk("tready", tready, e_rdy);
    chk("wr_en", wr_en, e_wr);
    if (e_wr) chk("wr_data", wr_data, e_data);

    acc     = tvalid & tready;
    wr_seen = wr_en;
    if (wr_en) begin
      wr_log.push_back(wr_data);
      wr_cyc.push_back(cyc);
    end
    if (gvld && !prev_gvld) begin
      gnt_log.push_back(int'(gidx));
      gnt_cyc.push_back(cyc);
    end
    prev_gvld = gvld;
    if (done) done_cnt++;

    if (rst_n) begin
      m_done = 0;
      if (!m_busy) begin
        for (int d = 1; d <= N; d++) begin
          if (!m_busy && tvalid[(m_ptr + d) % N]) begin
            m_busy  = 1;
            m_idx   = (m_ptr + d) % N;
            m_beats = 0;
          end
        end
      end else if (e_wr) begin
        m_beats++;
        if (tlast[m_idx] || m_beats == MB) begin
          m_done  = tlast[m_idx];
          m_busy  = 0;
          m_ptr   = m_idx;
          m_beats = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, g, dn, n;
    logic [DW-1:0] exp4 [7];
    int gexp [6];

    // Reset with all sources idle.
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      look();
      chk("t1_vld", gvld, 0);
      chk("t1_rdy", tready, 0);
      chk("t1_wr", wr_en, 0);
    end

    // Single 3-beat packet from source 2.
    tick();
    b  = wr_log.size();
    dn = done_cnt;
    send(2, 3, 'hA0);
    n = 0;
    do begin
      look();
      n++;
    end while (!tvalid[2] && n < 20);
    look();
    chk("t2_gvld", gvld, 1);
    chk("t2_gidx", gidx, 2);
    wait_idle(50);
    chk("t2_nwr", wr_log.size() - b, 3);
    if (wr_log.size() - b == 3) begin
      for (int i = 0; i < 3; i++)
        chk("t2_data", wr_log[b+i], 'hA0 + i);
      chk("t2_consec", wr_cyc[b+2] - wr_cyc[b], 2);
    end
    chk("t2_done", done_cnt - dn, 1);

    // Round robin over four always-valid sources.
    do_reset();
    g = gnt_log.size();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++)
        send(k, 1, DW'('hC0 + 16 * r + k));
    wait_idle(100);
    gexp = '{0, 1, 2, 3, 0, 1};
    chk("t3_ngnt", gnt_log.size() - g, 8);
    if (gnt_log.size() - g >= 6) begin
      for (int i = 0; i < 6; i++) chk("t3_order", gnt_log[g+i], gexp[i]);
      for (int i = 1; i < 6; i++)
        chk("t3_period", gnt_cyc[g+i] - gnt_cyc[g+i-1], 2);
    end

    // Oversized packet is forced out and resumed.
    do_reset();
    b  = wr_log.size();
    g  = gnt_log.size();
    dn = done_cnt;
    send(1, 6, 'hB0);
    send(3, 1, 'hD0);
    wait_idle(100);
    exp4 = '{'hB0, 'hB1, 'hB2, 'hB3, 'hD0, 'hB4, 'hB5};
    chk("t4_nwr", wr_log.size() - b, 7);
    if (wr_log.size() - b == 7)
      for (int i = 0; i < 7; i++) chk("t4_data", wr_log[b+i], exp4[i]);
    chk("t4_ngnt", gnt_log.size() - g, 3);
    if (gnt_log.size() - g == 3) begin
      chk("t4_g0", gnt_log[g], 1);
      chk("t4_g1", gnt_log[g+1], 3);
      chk("t4_g2", gnt_log[g+2], 1);
    end
    chk("t4_done", done_cnt - dn, 2);

    // FIFO full for five cycles mid-packet.
    do_reset();
    b  = wr_log.size();
    g  = gnt_log.size();
    dn = done_cnt;
    send(0, 4, 'hE0);
    n = 0;
    while (wr_log.size() == b && n < 20) begin
      look();
      n++;
    end
    chk("t5_start", n < 20, 1);
    force_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("t5_rdy", tready, 0);
      chk("t5_wr", wr_en, 0);
      chk("t5_hold", gvld, 1);
    end
    force_full = 1'b0;
    wait_idle(50);
    chk("t5_nwr", wr_log.size() - b, 4);
    if (wr_log.size() - b == 4)
      for (int i = 0; i < 4; i++) chk("t5_data", wr_log[b+i], 'hE0 + i);
    chk("t5_ngnt", gnt_log.size() - g, 1);
    chk("t5_done", done_cnt - dn, 1);

    // Reset pulse during a transfer.
    do_reset();
    b = wr_log.size();
    send(2, 3, 'hF0);
    n = 0;
    while (wr_log.size() == b && n < 20) begin
      look();
      n++;
    end
    send(0, 1, 'h90);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rdy", tready, 0);
    chk("t6_wr", wr_en, 0);
    tick();
    g = gnt_log.size();
    rst_n = 1'b1;
    n = 0;
    while (gnt_log.size() == g && n < 20) begin
      look();
      n++;
    end
    chk("t6_regrant", gnt_log.size() > g, 1);
    if (gnt_log.size() > g) chk("t6_first", gnt_log[g], 0);
    wait_idle(50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
